// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states, reset PC and IR field slices.
// The field slices are also used by the control decoder.
package ifetch_unit_pkg;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] PC_STEP_DEF  = 32'd4;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int FN_HI = 5;
  localparam int FN_LO = 0;

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, redirect input and decode handshake.
// master = fetch unit side, slave = memory/decode side.
interface ifetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [5:0]  id_opcode;
  logic [5:0]  id_funct;
  logic        if_misalign;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc, id_opcode, id_funct, if_misalign,
    input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc, id_opcode, id_funct, if_misalign,
    output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
  );

endinterface

// File: rtl/ifetch_unit_pc_reg.sv
// PC register with sequential increment, redirect load and (with IFETCH_ALIGN_CHECK_EN)
// rejection of misaligned redirect targets.
import ifetch_unit_pkg::*;

module ifetch_unit_pc_reg #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        redir,
  input  logic [31:0] redir_pc,
  output logic [31:0] pc,
  output logic        misalign
);

`ifdef IFETCH_ALIGN_CHECK_EN
  logic bad;
  logic misalign_q;

  assign bad = redir && (redir_pc[1:0] != 2'b00);

  // A rejected target leaves pc alone so the current instruction is refetched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      if (redir && !bad) begin
        pc <= redir_pc;
      end else if (inc) begin
        pc <= pc + PC_STEP;
      end
      misalign_q <= bad;
    end
  end

  assign misalign = misalign_q;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redir) begin
      pc <= redir_pc & ~32'd3;
    end else if (inc) begin
      pc <= pc + PC_STEP;
    end
  end

  assign misalign = 1'b0;
`endif

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: one-outstanding imem requests, IR latch and decode handshake.
// Optional redirect alignment check under IFETCH_ALIGN_CHECK_EN.
import ifetch_unit_pkg::*;

module ifetch_unit #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  ifetch_unit_if.master bus
);

  // state  | meaning
  // S_BOOT | first cycle after reset, nothing issued
  // S_REQ  | imem_req driven with imem_addr = pc
  // S_WAIT | one request outstanding; drop marks its word as stale
  // S_HOLD | IR valid, waiting for decode to take it

  state_t      state;
  logic        req_q;
  logic        valid_q;
  logic        drop;
  logic [31:0] ir;
  logic [31:0] id_pc_q;
  logic [31:0] pc;
  logic        misalign;
  logic        redir;
  logic        inc;

  assign redir = bus.redirect_valid && (state != S_BOOT);
  assign inc   = (state == S_HOLD) && bus.id_ready && !redir;

  ifetch_unit_pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (inc),
    .redir    (redir),
    .redir_pc (bus.redirect_pc),
    .pc       (pc),
    .misalign (misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_BOOT;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      drop    <= 1'b0;
      ir      <= '0;
      id_pc_q <= '0;
    end else begin
      case (state)
        S_BOOT: begin
          state <= S_REQ;
          req_q <= 1'b1;
        end
        S_REQ: begin
          req_q <= 1'b0;
          state <= S_WAIT;
          drop  <= redir;
        end
        S_WAIT: begin
          if (bus.imem_rvalid) begin
            // A redirect arriving with the word makes it stale too; no drop needed.
            if (drop || redir) begin
              drop  <= 1'b0;
              state <= S_REQ;
              req_q <= 1'b1;
            end else begin
              ir      <= bus.imem_rdata;
              id_pc_q <= pc;
              valid_q <= 1'b1;
              state   <= S_HOLD;
            end
          end else if (redir) begin
            drop <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redir || bus.id_ready) begin
            valid_q <= 1'b0;
            state   <= S_REQ;
            req_q   <= 1'b1;
          end
        end
        default: state <= S_BOOT;
      endcase
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc;
  assign bus.id_valid    = valid_q;
  assign bus.id_instr    = ir;
  assign bus.id_pc       = id_pc_q;
  assign bus.id_opcode   = ir[OP_HI:OP_LO];
  assign bus.id_funct    = ir[FN_HI:FN_LO];
  assign bus.if_misalign = misalign;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a variable-latency instruction memory model.
module tb_ifetch_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   lat = 1;
  int   pend = 0;
  logic [31:0] pend_addr = '0;
  int   last_req_cyc = 0;
  int   valid_cnt = 0;

  ifetch_unit_if bus();

  ifetch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_3000) return 32'h0000_0020;
    return {a[15:0], 16'h1234};
  endfunction

  // Memory answers lat cycles after it sees imem_req; rvalid straddles one rising edge.
  always @(negedge clk) begin
    bus.imem_rvalid = 1'b0;
    if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(pend_addr);
      end
    end
    if (bus.imem_req) begin
      pend      = lat;
      pend_addr = bus.imem_addr;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h want %h", tag, act, exp);
    else n_pass++;
  endtask

  task automatic wait_req(input string tag, input logic [31:0] exp_addr);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.id_valid) valid_cnt++;
      if (bus.imem_req) seen = 1;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    check({tag, "_addr"}, bus.imem_addr, exp_addr);
  endtask

  task automatic wait_valid(input string tag);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.id_valid) seen = 1;
    end
    check({tag, "_valid"}, 32'(seen), 32'd1);
  endtask

  initial begin
    bus.id_ready       = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = '0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_valid", 32'(bus.id_valid), 32'd0);
    check("rst_instr", bus.id_instr, 32'd0);
    check("rst_idpc", bus.id_pc, 32'd0);
    check("rst_addr", bus.imem_addr, 32'h3000);
    check("rst_misal", 32'(bus.if_misalign), 32'd0);
    rst_n = 1'b1;

    // sequential fetch, 1-cycle memory, decode always ready
    wait_req("seq0", 32'h3000);
    last_req_cyc = cyc;
    wait_valid("add");
    check("add_instr", bus.id_instr, 32'h0000_0020);
    check("add_op", 32'(bus.id_opcode), 32'h00);
    check("add_fn", 32'(bus.id_funct), 32'h20);
    check("add_pc", bus.id_pc, 32'h3000);
    wait_req("seq1", 32'h3004);
    check("seq1_gap", 32'(cyc - last_req_cyc), 32'd3);
    last_req_cyc = cyc;
    wait_req("seq2", 32'h3008);
    check("seq2_gap", 32'(cyc - last_req_cyc), 32'd3);

    // decode stall in S_HOLD
    bus.id_ready = 1'b0;
    wait_valid("hold");
    lat = 3;
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 32'(bus.id_valid), 32'd1);
      check("hold_noreq", 32'(bus.imem_req), 32'd0);
      check("hold_instr", bus.id_instr, 32'h3008_1234);
      @(negedge clk);
    end
    bus.id_ready = 1'b1;
    wait_req("hold_next", 32'h300C);

    // redirect while waiting on a 3-cycle memory: stale word must be dropped
    @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h3100;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    valid_cnt = 0;
    wait_req("drop_req", 32'h3100);
    check("drop_nostale", 32'(valid_cnt), 32'd0);
    wait_valid("drop");
    lat = 1;
    check("drop_instr", bus.id_instr, 32'h3100_1234);
    check("drop_pc", bus.id_pc, 32'h3100);
    check("drop_op", 32'(bus.id_opcode), 32'h0C);
    check("drop_fn", 32'(bus.id_funct), 32'h34);

    // redirect and id_ready together in S_HOLD
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h3200;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    check("rr_valid", 32'(bus.id_valid), 32'd0);
    check("rr_req", 32'(bus.imem_req), 32'd1);
    check("rr_addr", bus.imem_addr, 32'h3200);

    // misaligned redirect target
    bus.id_ready = 1'b0;
    wait_valid("mis");
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h3302;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
    check("mis_pulse", 32'(bus.if_misalign), 32'd1);
    check("mis_addr", bus.imem_addr, 32'h3200);
`else
    check("mis_pulse", 32'(bus.if_misalign), 32'd0);
    check("mis_addr", bus.imem_addr, 32'h3300);
`endif
    check("mis_valid", 32'(bus.id_valid), 32'd0);
    check("mis_req", 32'(bus.imem_req), 32'd1);
    @(negedge clk);
    check("mis_end", 32'(bus.if_misalign), 32'd0);

    // PC wrap at the top of the address space
    wait_valid("wrap_pre");
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    check("wrap_req", 32'(bus.imem_req), 32'd1);
    check("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    bus.id_ready = 1'b1;
    wait_valid("wrap");
    lat = 3;
    check("wrap_pc", bus.id_pc, 32'hFFFF_FFFC);
    check("wrap_instr", bus.id_instr, 32'hFFFC_1234);
    wait_req("wrap_next", 32'h0000_0000);

    // reset mid-fetch; the late word arrives while in S_REQ and is ignored
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    lat = 1;
    check("mrst_valid", 32'(bus.id_valid), 32'd0);
    check("mrst_req", 32'(bus.imem_req), 32'd0);
    check("mrst_addr", bus.imem_addr, 32'h3000);
    rst_n = 1'b1;
    wait_req("mrst_fetch", 32'h3000);
    wait_valid("mrst");
    check("mrst_instr", bus.id_instr, 32'h0000_0020);
    check("mrst_pc", bus.id_pc, 32'h3000);
    check("mrst_fn", 32'(bus.id_funct), 32'h20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
